// File: rtl/mod_switch_param.sv
// mod_switch_param: multi-cycle RNS ModDown engine, out_j = (x_Bj - FastBConv(x_q)_j) * q^-1 mod b_j.
// Define MODSWITCH_ROUND_EN to add floor(q/2) before conversion, giving round(X/q) instead of floor.
module mod_switch_param #(
    parameter int N_SLOTS = 8,
    parameter int Q_LEN   = 2,
    parameter int B_LEN   = 3,
    parameter int W       = 32,
    parameter int LANES   = 2
) (
    input  logic                                       clk,
    input  logic                                       reset,
    input  logic                                       in_valid,
    output logic                                       in_ready,
    input  logic [N_SLOTS-1:0][Q_LEN+B_LEN-1:0][W-1:0] in_poly,
    input  logic [Q_LEN-1:0][W-1:0]                    q_mod,
    input  logic [B_LEN-1:0][W-1:0]                    b_mod,
    input  logic [Q_LEN-1:0][W-1:0]                    qhat_inv,
    input  logic [Q_LEN-1:0][B_LEN-1:0][W-1:0]         qhat_mod_b,
    input  logic [B_LEN-1:0][W-1:0]                    q_inv_mod_b,
    input  logic [Q_LEN-1:0][W-1:0]                    half_q_mod_q,
    input  logic [B_LEN-1:0][W-1:0]                    half_q_mod_b,
    output logic                                       out_valid,
    input  logic                                       out_ready,
    output logic [N_SLOTS-1:0][B_LEN-1:0][W-1:0]       out_poly
);

    localparam int R_LEN = Q_LEN + B_LEN;
    localparam int G     = N_SLOTS / LANES;
    localparam int GW    = (G > 1) ? $clog2(G) : 1;
    localparam int IW    = (Q_LEN > 1) ? $clog2(Q_LEN) : 1;
    localparam int SW    = (N_SLOTS > 1) ? $clog2(N_SLOTS) : 1;

    if (N_SLOTS % LANES != 0) begin : g_bad_lanes
        $error("mod_switch_param: LANES (%0d) must divide N_SLOTS (%0d)", LANES, N_SLOTS);
    end

    typedef enum logic [2:0] {S_IDLE, S_LOAD, S_ACC, S_FIN, S_DONE} state_t;

    function automatic logic [W-1:0] mul_mod(input logic [W-1:0] a, input logic [W-1:0] b,
                                             input logic [W-1:0] m);
        logic [2*W-1:0] p;
        p = (2*W)'(a) * (2*W)'(b);
        return W'(p % (2*W)'(m));
    endfunction

    function automatic logic [W-1:0] add_mod(input logic [W-1:0] a, input logic [W-1:0] b,
                                             input logic [W-1:0] m);
        logic [W:0] s;
        s = {1'b0, a} + {1'b0, b};
        if (s >= {1'b0, m}) s = s - {1'b0, m};
        return s[W-1:0];
    endfunction

    // a - b mod m, formed as a + m - b so the intermediate never goes negative
    function automatic logic [W-1:0] sub_mod(input logic [W-1:0] a, input logic [W-1:0] b,
                                             input logic [W-1:0] m);
        logic [W:0] s;
        s = {1'b0, a} + {1'b0, m} - {1'b0, b};
        if (s >= {1'b0, m}) s = s - {1'b0, m};
        return s[W-1:0];
    endfunction

    function automatic logic [SW-1:0] slot_idx(input logic [GW-1:0] g, input int l);
        return SW'(int'(g) * LANES + l);
    endfunction

    state_t                                 state_q;
    logic [GW-1:0]                          g_q;
    logic [IW-1:0]                          i_q;
    logic                                   out_valid_q;
    logic [N_SLOTS-1:0][R_LEN-1:0][W-1:0]   x_q;
    logic [LANES-1:0][Q_LEN-1:0][W-1:0]     y_q, y_d;
    logic [LANES-1:0][B_LEN-1:0][W-1:0]     acc_q, acc_d, res_d;
    logic [N_SLOTS-1:0][B_LEN-1:0][W-1:0]   out_q;
    logic [LANES-1:0][SW-1:0]               sidx;

`ifndef MODSWITCH_ROUND_EN
    logic unused_half;
    assign unused_half = ^{half_q_mod_q, half_q_mod_b};
`endif

    always_comb begin
        for (int l = 0; l < LANES; l++) sidx[l] = slot_idx(g_q, l);
    end

    // Candidate next values for the LOAD, ACC and FIN steps of every lane
    always_comb begin : p_datapath
        logic [W-1:0] xq;
        logic [W-1:0] xb;
        xq    = '0;
        xb    = '0;
        y_d   = '0;
        acc_d = '0;
        res_d = '0;
        for (int l = 0; l < LANES; l++) begin
            for (int i = 0; i < Q_LEN; i++) begin
                xq = x_q[sidx[l]][i];
`ifdef MODSWITCH_ROUND_EN
                xq = add_mod(xq, half_q_mod_q[i], q_mod[i]);
`endif
                y_d[l][i] = mul_mod(xq, qhat_inv[i], q_mod[i]);
            end
            for (int j = 0; j < B_LEN; j++) begin
                acc_d[l][j] = add_mod(acc_q[l][j],
                                      mul_mod(y_q[l][i_q], qhat_mod_b[i_q][j], b_mod[j]),
                                      b_mod[j]);
                xb = x_q[sidx[l]][Q_LEN+j];
`ifdef MODSWITCH_ROUND_EN
                xb = add_mod(xb, half_q_mod_b[j], b_mod[j]);
`endif
                res_d[l][j] = mul_mod(sub_mod(xb, acc_q[l][j], b_mod[j]), q_inv_mod_b[j], b_mod[j]);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_IDLE;
            g_q         <= '0;
            i_q         <= '0;
            out_valid_q <= 1'b0;
            out_q       <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (in_valid) begin
                        x_q     <= in_poly;
                        g_q     <= '0;
                        state_q <= S_LOAD;
                    end
                end
                S_LOAD: begin
                    y_q     <= y_d;
                    acc_q   <= '0;
                    i_q     <= '0;
                    state_q <= S_ACC;
                end
                S_ACC: begin
                    acc_q <= acc_d;
                    i_q   <= i_q + 1'b1;
                    if (i_q == IW'(Q_LEN - 1)) state_q <= S_FIN;
                end
                S_FIN: begin
                    for (int l = 0; l < LANES; l++) out_q[sidx[l]] <= res_d[l];
                    if (g_q == GW'(G - 1)) begin
                        state_q     <= S_DONE;
                        out_valid_q <= 1'b1;
                    end else begin
                        g_q     <= g_q + 1'b1;
                        state_q <= S_LOAD;
                    end
                end
                S_DONE: begin
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        state_q     <= S_IDLE;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign in_ready  = (state_q == S_IDLE) && !reset;
    assign out_valid = out_valid_q;
    assign out_poly  = out_q;

endmodule

// File: tb/tb_mod_switch_param.sv
// Bench for mod_switch_param: exact small-modulus cases, random default-size polynomials against
// a residue model, backpressure, mid-operation reset, and LANES=N_SLOTS / LANES=1 variants.
module tb_mod_switch_param;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset;
    int   n_checks = 0;
    int   n_pass   = 0;
    logic [767:0] sb[$];

    task automatic check(input string tag, input logic [767:0] got, input logic [767:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Default configuration constants (Q_LEN=2, B_LEN=3), shared by u_a, u_g1 and u_g8
    logic [1:0][31:0]       c_q, c_qhi, c_hq;
    logic [2:0][31:0]       c_b, c_qib, c_hb;
    logic [1:0][2:0][31:0]  c_qmb;
    logic [7:0][4:0][31:0]  a_poly;

    logic                   a_valid, a_ready, a_ovalid, a_oready;
    logic [7:0][2:0][31:0]  a_out;
    logic                   g_valid, g1_ready, g1_ovalid, g8_ready, g8_ovalid;
    logic [7:0][2:0][31:0]  g1_out, g8_out;

    // Small configuration: q={7}, B={11,13}
    logic [0:0][31:0]       s_q, s_qhi, s_hq;
    logic [1:0][31:0]       s_b, s_qib, s_hb;
    logic [0:0][1:0][31:0]  s_qmb;
    logic [7:0][2:0][31:0]  s_poly;
    logic                   s_valid, s_ready, s_ovalid, s_oready;
    logic [7:0][1:0][31:0]  s_out;

    mod_switch_param #(.N_SLOTS(8), .Q_LEN(2), .B_LEN(3), .W(32), .LANES(2)) u_a (
        .clk(clk), .reset(reset), .in_valid(a_valid), .in_ready(a_ready), .in_poly(a_poly),
        .q_mod(c_q), .b_mod(c_b), .qhat_inv(c_qhi), .qhat_mod_b(c_qmb), .q_inv_mod_b(c_qib),
        .half_q_mod_q(c_hq), .half_q_mod_b(c_hb),
        .out_valid(a_ovalid), .out_ready(a_oready), .out_poly(a_out));

    mod_switch_param #(.N_SLOTS(8), .Q_LEN(2), .B_LEN(3), .W(32), .LANES(8)) u_g1 (
        .clk(clk), .reset(reset), .in_valid(g_valid), .in_ready(g1_ready), .in_poly(a_poly),
        .q_mod(c_q), .b_mod(c_b), .qhat_inv(c_qhi), .qhat_mod_b(c_qmb), .q_inv_mod_b(c_qib),
        .half_q_mod_q(c_hq), .half_q_mod_b(c_hb),
        .out_valid(g1_ovalid), .out_ready(1'b1), .out_poly(g1_out));

    mod_switch_param #(.N_SLOTS(8), .Q_LEN(2), .B_LEN(3), .W(32), .LANES(1)) u_g8 (
        .clk(clk), .reset(reset), .in_valid(g_valid), .in_ready(g8_ready), .in_poly(a_poly),
        .q_mod(c_q), .b_mod(c_b), .qhat_inv(c_qhi), .qhat_mod_b(c_qmb), .q_inv_mod_b(c_qib),
        .half_q_mod_q(c_hq), .half_q_mod_b(c_hb),
        .out_valid(g8_ovalid), .out_ready(1'b1), .out_poly(g8_out));

    mod_switch_param #(.N_SLOTS(8), .Q_LEN(1), .B_LEN(2), .W(32), .LANES(2)) u_s (
        .clk(clk), .reset(reset), .in_valid(s_valid), .in_ready(s_ready), .in_poly(s_poly),
        .q_mod(s_q), .b_mod(s_b), .qhat_inv(s_qhi), .qhat_mod_b(s_qmb), .q_inv_mod_b(s_qib),
        .half_q_mod_q(s_hq), .half_q_mod_b(s_hb),
        .out_valid(s_ovalid), .out_ready(s_oready), .out_poly(s_out));

    function automatic logic [63:0] mm(input logic [63:0] a, input logic [63:0] b,
                                       input logic [63:0] m);
        return (a * b) % m;
    endfunction

    function automatic logic [63:0] inv(input logic [63:0] a, input logic [63:0] m);
        longint t, nt, r, nr, qq, tmp;
        t = 0; nt = 1; r = longint'(m); nr = longint'(a % m);
        while (nr != 0) begin
            qq = r / nr;
            tmp = t - qq * nt; t = nt; nt = tmp;
            tmp = r - qq * nr; r = nr; nr = tmp;
        end
        if (t < 0) t = t + longint'(m);
        return 64'(t);
    endfunction

    function automatic logic [767:0] model_a(input logic [7:0][4:0][31:0] p);
        logic [7:0][2:0][31:0] o;
        logic [1:0][63:0]      y;
        logic [63:0]           x, acc, xb;
        for (int s = 0; s < 8; s++) begin
            for (int i = 0; i < 2; i++) begin
                x = 64'(p[s][i]);
`ifdef MODSWITCH_ROUND_EN
                x = (x + 64'(c_hq[i])) % 64'(c_q[i]);
`endif
                y[i] = mm(x, 64'(c_qhi[i]), 64'(c_q[i]));
            end
            for (int j = 0; j < 3; j++) begin
                acc = (mm(y[0], 64'(c_qmb[0][j]), 64'(c_b[j])) +
                       mm(y[1], 64'(c_qmb[1][j]), 64'(c_b[j]))) % 64'(c_b[j]);
                xb = 64'(p[s][2+j]);
`ifdef MODSWITCH_ROUND_EN
                xb = (xb + 64'(c_hb[j])) % 64'(c_b[j]);
`endif
                o[s][j] = 32'(mm((xb + 64'(c_b[j]) - acc) % 64'(c_b[j]), 64'(c_qib[j]), 64'(c_b[j])));
            end
        end
        return o;
    endfunction

    // With a single q modulus the result is exact: floor (or round) of X/7, reduced mod 11 and 13
    function automatic logic [767:0] model_s(input int xs[8]);
        logic [7:0][1:0][31:0] o;
        int v;
        for (int s = 0; s < 8; s++) begin
`ifdef MODSWITCH_ROUND_EN
            v = (xs[s] + 3) / 7;
`else
            v = xs[s] / 7;
`endif
            o[s][0] = 32'(v % 11);
            o[s][1] = 32'(v % 13);
        end
        return 768'(o);
    endfunction

    task automatic init_consts();
        logic [63:0] half;
        c_q[0] = 32'd4294967291; c_q[1] = 32'd4294967279;
        c_b[0] = 32'd4294967231; c_b[1] = 32'd4294967197; c_b[2] = 32'd4294967189;
        for (int j = 0; j < 3; j++) begin
            c_qmb[0][j] = c_q[1] % c_b[j];
            c_qmb[1][j] = c_q[0] % c_b[j];
            c_qib[j] = 32'(inv(mm(64'(c_qmb[0][j]), 64'(c_qmb[1][j]), 64'(c_b[j])), 64'(c_b[j])));
        end
        c_qhi[0] = 32'(inv(64'(c_q[1] % c_q[0]), 64'(c_q[0])));
        c_qhi[1] = 32'(inv(64'(c_q[0] % c_q[1]), 64'(c_q[1])));
        half = (64'(c_q[0]) * 64'(c_q[1])) >> 1;
        for (int i = 0; i < 2; i++) c_hq[i] = 32'(half % 64'(c_q[i]));
        for (int j = 0; j < 3; j++) c_hb[j] = 32'(half % 64'(c_b[j]));
        s_q[0] = 32'd7; s_qhi[0] = 32'd1; s_hq[0] = 32'd3;
        s_b[0] = 32'd11; s_b[1] = 32'd13;
        s_qib[0] = 32'd8; s_qib[1] = 32'd2;
        s_qmb[0][0] = 32'd1; s_qmb[0][1] = 32'd1;
        s_hb[0] = 32'd3; s_hb[1] = 32'd3;
    endtask

    task automatic rand_a_poly();
        for (int s = 0; s < 8; s++) begin
            for (int r = 0; r < 5; r++) begin
                if (r < 2) a_poly[s][r] = $urandom % c_q[r];
                else       a_poly[s][r] = $urandom % c_b[r-2];
            end
        end
    endtask

    task automatic run_s(input int xs[8], input string tag);
        logic [767:0] exp;
        for (int s = 0; s < 8; s++) begin
            s_poly[s][0] = 32'(xs[s] % 7);
            s_poly[s][1] = 32'(xs[s] % 11);
            s_poly[s][2] = 32'(xs[s] % 13);
        end
        sb.push_back(model_s(xs));
        s_valid = 1'b1;
        tick();
        s_valid = 1'b0;
        check({tag, "_busy"}, s_ready, 0);
        repeat (11) tick();
        check({tag, "_early"}, s_ovalid, 0);
        tick();
        check({tag, "_lat12"}, s_ovalid, 1);
        exp = sb.pop_front();
        check({tag, "_data"}, s_out, exp);
        tick();
        check({tag, "_idle"}, s_ready, 1);
    endtask

    task automatic run_a(input string tag);
        logic [767:0] exp;
        rand_a_poly();
        sb.push_back(model_a(a_poly));
        a_valid = 1'b1;
        tick();
        a_valid = 1'b0;
        check({tag, "_busy"}, a_ready, 0);
        repeat (15) tick();
        check({tag, "_early"}, a_ovalid, 0);
        tick();
        check({tag, "_lat16"}, a_ovalid, 1);
        exp = sb.pop_front();
        for (int s = 0; s < 8; s++)
            check($sformatf("%s_slot%0d", tag, s), 768'(a_out[s]), exp[s*96 +: 96]);
        tick();
        check({tag, "_one_cycle"}, a_ovalid, 0);
        check({tag, "_idle"}, a_ready, 1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int           xs[8];
        int           n;
        logic [767:0] exp;

        init_consts();
        reset = 1'b1;
        a_valid = 1'b0; g_valid = 1'b0; s_valid = 1'b0;
        a_oready = 1'b1; s_oready = 1'b1;
        a_poly = '0; s_poly = '0;
        repeat (3) tick();
        check("rst_in_ready", a_ready, 0);
        check("rst_out_valid", a_ovalid, 0);
        check("rst_out_poly", a_out, 0);
        reset = 1'b0;
        #1;
        check("post_rst_in_ready", a_ready, 1);
        tick();

        // Small exact cases: X=100 gives (3,1); X=104 gives (3,1) floored or (4,2) rounded
        xs = '{100, 104, 213, 326, 439, 552, 665, 891};
        run_s(xs, "s_fixed");
        check("s_x100", 768'(s_out[0]), {32'd1, 32'd3});
`ifdef MODSWITCH_ROUND_EN
        check("s_x104", 768'(s_out[1]), {32'd2, 32'd4});
`else
        check("s_x104", 768'(s_out[1]), {32'd1, 32'd3});
`endif
        for (int s = 0; s < 8; s++) xs[s] = int'($urandom_range(989, 0));
        run_s(xs, "s_rand");

        run_a("a_rand0");
        run_a("a_rand1");

        // Backpressure: result must hold while a second offer is refused
        a_oready = 1'b0;
        rand_a_poly();
        sb.push_back(model_a(a_poly));
        a_valid = 1'b1;
        tick();
        rand_a_poly();
        n = 0;
        while (!a_ovalid && n < 40) begin
            tick();
            n++;
        end
        check("bp_latency", n, 16);
        exp = sb.pop_front();
        for (int c = 0; c < 20; c++) begin
            check("bp_hold_valid", a_ovalid, 1);
            check("bp_hold_data", a_out, exp);
            check("bp_hold_ready", a_ready, 0);
            tick();
        end
        a_oready = 1'b1;
        tick();
        a_valid = 1'b0;
        check("bp_release_valid", a_ovalid, 0);
        check("bp_release_ready", a_ready, 1);
        tick();
        check("bp_no_second", a_ready, 1);

        // Reset during ACC of group 2 discards the in-flight polynomial
        rand_a_poly();
        sb.push_back(model_a(a_poly));
        a_valid = 1'b1;
        tick();
        a_valid = 1'b0;
        repeat (9) tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        #1;
        void'(sb.pop_back());
        check("midrst_out_valid", a_ovalid, 0);
        check("midrst_out_poly", a_out, 0);
        check("midrst_in_ready", a_ready, 1);
        run_a("a_after_rst");

        // One group of 8 lanes versus eight groups of one lane on the same input
        rand_a_poly();
        sb.push_back(model_a(a_poly));
        g_valid = 1'b1;
        tick();
        g_valid = 1'b0;
        exp = sb.pop_front();
        for (int t = 1; t <= 34; t++) begin
            tick();
            if (t == 3)  check("g1_early", g1_ovalid, 0);
            if (t == 4) begin
                check("g1_lat4", g1_ovalid, 1);
                check("g1_data", g1_out, exp);
            end
            if (t == 31) check("g8_early", g8_ovalid, 0);
            if (t == 32) begin
                check("g8_lat32", g8_ovalid, 1);
                check("g8_data", g8_out, exp);
            end
        end
        check("g_sb_empty", sb.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
